wvb_dpram_drain: RTL and testbench

Downstream consumer of the waveform-buffer reader's DPRAM handoff. On each `dpram_run` pulse it owns the DPRAM read port and streams `dpram_len` 32-bit words, starting at address 0, out on a valid/ready word stream toward the host link. It then releases the DPRAM by dropping `dpram_busy`. Read latency is hidden by a credit-managed skid FIFO, so throughput is one word per cycle under continuous `out_ready`.

---
 rtl/wvb_drain_pkg.sv | 15 +
 rtl/wvb_drain_fifo.sv | 99 +++++++++
 rtl/wvb_dpram_drain.sv | 142 ++++++++++++++
 tb/tb_wvb_dpram_drain.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_drain_pkg.sv
// Shared definitions for the waveform-buffer DPRAM drain.
//   drain_state_t : drain FSM encoding
//   CNT_W         : width of the issue/sent/length counters (holds 65536)
package wvb_drain_pkg;

  localparam int unsigned CNT_W = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } drain_state_t;

endpackage

// File: rtl/wvb_drain_fifo.sv
// Skid FIFO between the DPRAM read pipeline and the output word stream.
// The head word sits in an output register; entries behind it live in a
// small circular buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : write strobe, wr_data/wr_last captured when high
//   rd_ready   : consumer accepts the head word this cycle
//   rd_valid   : head word valid; rd_data/rd_last stable until accepted
//   count      : total occupancy (buffer + output register)
module wvb_drain_fifo #(
  parameter int unsigned P_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [31:0]                    wr_data,
  input  logic                           wr_last,
  input  logic                           rd_ready,
  output logic [31:0]                    rd_data,
  output logic                           rd_last,
  output logic                           rd_valid,
  output logic [$clog2(P_DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int unsigned CW = $clog2(P_DEPTH + 1);

  logic [32:0]   mem [P_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] mem_cnt_q;
  logic [31:0]   dout_q;
  logic          dout_last_q;
  logic          dout_valid_q;

  logic advance;
  logic from_mem;
  logic bypass;
  logic mem_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The output register reloads whenever it is empty or being consumed;
  // with an empty buffer a write goes straight into it.
  always_comb begin
    advance  = !dout_valid_q || rd_ready;
    from_mem = advance && (mem_cnt_q != '0);
    bypass   = advance && (mem_cnt_q == '0) && wr_en;
    mem_wr   = wr_en && !bypass;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_q] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      dout_q       <= '0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (from_mem) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({mem_wr, from_mem})
        2'b10:   mem_cnt_q <= mem_cnt_q + 1'b1;
        2'b01:   mem_cnt_q <= mem_cnt_q - 1'b1;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
      if (advance) begin
        if (from_mem) begin
          {dout_last_q, dout_q} <= mem[rd_ptr_q];
          dout_valid_q          <= 1'b1;
        end else if (bypass) begin
          dout_q       <= wr_data;
          dout_last_q  <= wr_last;
          dout_valid_q <= 1'b1;
        end else begin
          dout_valid_q <= 1'b0;
        end
      end
    end
  end

  assign rd_data  = dout_q;
  assign rd_last  = dout_last_q;
  assign rd_valid = dout_valid_q;
  assign count    = mem_cnt_q + CW'(dout_valid_q);

endmodule

// File: rtl/wvb_dpram_drain.sv
// Drains a DPRAM filled by the waveform-buffer reader onto a valid/ready
// word stream. Each dpram_run pulse streams dpram_len words from address 0,
// then releases the DPRAM by dropping dpram_busy.
//   clk, rst       : clock, asynchronous active-high reset
//   dpram_run/len  : start pulse and word count (len sampled with run)
//   dpram_busy     : DPRAM owned by this block
//   dpram_rd_*     : DPRAM read port, data P_RD_LATENCY cycles after strobe
//   out_*          : output word stream, out_last marks the final word
//   len_err        : one-cycle pulse for a zero or oversized length
module wvb_dpram_drain
  import wvb_drain_pkg::*;
#(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 10,
  parameter int unsigned P_RD_LATENCY      = 2,
  parameter int unsigned P_FIFO_DEPTH      = P_RD_LATENCY + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dpram_run,
  input  logic [15:0]                  dpram_len,
  output logic                         dpram_busy,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  output logic                         dpram_rd_en,
  input  logic [31:0]                  dpram_rd_data,
  output logic [31:0]                  out_data,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         len_err
);

  localparam int unsigned FCW = $clog2(P_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] D_WORDS = CNT_W'(2 ** P_DPRAM_ADR_WIDTH);

  drain_state_t state_q;
  drain_state_t state_d;

  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        issued_q;
  logic [CNT_W-1:0]        sent_q;
  logic [P_RD_LATENCY-1:0] vld_q;
  logic [P_RD_LATENCY-1:0] last_q;
  logic                    len_err_q;

  logic [CNT_W-1:0] len_ext;
  logic [CNT_W-1:0] len_eff;
  logic             len_bad;
  logic             start;
  logic             issue;
  logic             last_tag;
  logic             hs;
  logic [CNT_W-1:0] inflight;
  logic [FCW-1:0]   fifo_count;

  always_comb begin
    len_ext  = {1'b0, dpram_len};
    len_eff  = (len_ext > D_WORDS) ? D_WORDS : len_ext;
    len_bad  = (dpram_len == '0) || (len_ext > D_WORDS);
    start    = (state_q == S_IDLE) && dpram_run;
    hs       = out_valid && out_ready;
    last_tag = (issued_q == len_q - 1'b1);

    inflight = '0;
    for (int unsigned i = 0; i < P_RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end

    // Credit: every read in flight already has a FIFO slot reserved.
    issue = (state_q == S_READ) && (issued_q < len_q) &&
            ((inflight + CNT_W'(fifo_count)) < CNT_W'(P_FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dpram_run) state_d = (dpram_len == '0) ? S_DONE : S_READ;
      S_READ:  if (issued_q == len_q) state_d = S_FLUSH;
      // Leave on the final handshake itself so busy drops two cycles later.
      S_FLUSH: if ((sent_q == len_q) || (hs && (sent_q == len_q - 1'b1)))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      vld_q     <= '0;
      last_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= start && len_bad;
      if (start) begin
        len_q    <= len_eff;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 1'b1;
        if (hs)    sent_q   <= sent_q + 1'b1;
      end
      // Read-latency tracker; the last-word tag travels with its read.
      vld_q[0]  <= issue;
      last_q[0] <= issue && last_tag;
      for (int unsigned i = 1; i < P_RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  wvb_drain_fifo #(
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_q[P_RD_LATENCY-1]),
    .wr_data  (dpram_rd_data),
    .wr_last  (last_q[P_RD_LATENCY-1]),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_last  (out_last),
    .rd_valid (out_valid),
    .count    (fifo_count)
  );

  assign dpram_busy    = (state_q != S_IDLE);
  assign dpram_rd_en   = issue;
  assign dpram_rd_addr = issued_q[P_DPRAM_ADR_WIDTH-1:0];
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_wvb_dpram_drain.sv
// Bench for wvb_dpram_drain: directed transfers, expected words queued at
// issue time and compared by an independent stream monitor.
module tb_wvb_dpram_drain;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned D   = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          dpram_run;
  logic [15:0]   dpram_len;
  logic          dpram_busy;
  logic [AW-1:0] dpram_rd_addr;
  logic          dpram_rd_en;
  logic [31:0]   dpram_rd_data;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          len_err;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ready_mode = 0;
  logic [15:0] dp_seed  = 16'h0;
  int unsigned exp_addr = 0;
  int unsigned ovf      = 0;

  logic [31:0] hold_d;
  logic        hold_l;
  logic        hold_v = 1'b0;
  logic [31:0] pipe [LAT];

  wvb_dpram_drain #(
    .P_DPRAM_ADR_WIDTH (AW),
    .P_RD_LATENCY      (LAT),
    .P_FIFO_DEPTH      (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dpram_run     (dpram_run),
    .dpram_len     (dpram_len),
    .dpram_busy    (dpram_busy),
    .dpram_rd_addr (dpram_rd_addr),
    .dpram_rd_en   (dpram_rd_en),
    .dpram_rd_data (dpram_rd_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DPRAM model: word = {seed, 6'h0, addr}, LAT cycles after a strobe.
  always @(posedge clk) begin
    pipe[0] <= dpram_rd_en ? {dp_seed, 6'h0, dpram_rd_addr} : 32'hdead_beef;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dpram_rd_data = pipe[LAT-1];

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  task automatic chk_eq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input longint act);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d (condition not met)", name, act);
    end
  endtask

  // Stream monitor: scoreboard pop, hold-stability, address order, occupancy.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk_ok("stall_stable", out_valid && out_data == hold_d && out_last == hold_l,
               longint'(out_data));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_eq("unexpected_word", longint'(out_data), 0);
        end else begin
          e = sb.pop_front();
          chk_eq("word", longint'({out_last, out_data}), longint'({e.l, e.d}));
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (dpram_rd_en) begin
        chk_eq("rd_addr", longint'(dpram_rd_addr), longint'(exp_addr % D));
        exp_addr++;
      end
      if (dut.fifo_count > 3'(FD)) ovf++;
    end
  end

  task automatic check_reset_outs(input string tag);
    chk_eq({tag, "_busy"},  longint'(dpram_busy), 0);
    chk_eq({tag, "_rd_en"}, longint'(dpram_rd_en), 0);
    chk_eq({tag, "_addr"},  longint'(dpram_rd_addr), 0);
    chk_eq({tag, "_valid"}, longint'(out_valid), 0);
    chk_eq({tag, "_last"},  longint'(out_last), 0);
    chk_eq({tag, "_data"},  longint'(out_data), 0);
    chk_eq({tag, "_lenerr"}, longint'(len_err), 0);
  endtask

  task automatic do_xfer(input string name, input int unsigned len, input logic [15:0] seed,
                         input int rmode, input int repulse_at, input int rst_at);
    int unsigned n, words, rds, errs, busy_cycles, budget;
    int run_cyc, rise_cyc, fall_cyc, fv_cyc, lhs_cyc, err_cyc, first_rd, last_rd;
    bit done, repulsed, exp_err;
    n = (len > D) ? D : len;
    exp_err = (len == 0) || (len > D);
    words = 0; rds = 0; errs = 0; busy_cycles = 0;
    rise_cyc = -1; fall_cyc = -1; fv_cyc = -1; lhs_cyc = -1; err_cyc = -1;
    first_rd = -1; last_rd = -1; done = 0; repulsed = 0;
    budget = n * 4 + 40;
    dp_seed = seed;
    ready_mode = rmode;
    exp_addr = 0;
    for (int unsigned a = 0; a < n; a++) begin
      sb.push_back('{d: {seed, 6'h0, a[9:0]}, l: (a == n - 1)});
    end
    @(negedge clk);
    dpram_len = len[15:0];
    dpram_run = 1'b1;
    run_cyc = cyc;
    @(negedge clk);
    dpram_run = 1'b0;
    for (int unsigned k = 0; k < budget && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (dpram_busy) begin
        busy_cycles++;
        if (rise_cyc < 0) rise_cyc = cyc;
      end else if (rise_cyc >= 0 && fall_cyc < 0) begin
        fall_cyc = cyc;
        done = 1;
      end
      if (len_err) begin errs++; err_cyc = cyc; end
      if (dpram_rd_en) begin
        rds++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (out_valid && fv_cyc < 0) fv_cyc = cyc;
      if (out_valid && out_ready) begin
        words++;
        if (out_last) lhs_cyc = cyc;
      end
      if (repulse_at >= 0 && words == repulse_at && !repulsed) begin
        dpram_len = 16'd5;
        dpram_run = 1'b1;
        repulsed = 1;
      end else begin
        dpram_run = 1'b0;
      end
      if (rst_at >= 0 && words == rst_at) begin
        #1 rst = 1'b1;
        #1 check_reset_outs({name, "_midrst"});
        sb.delete();
        return;
      end
    end
    chk_eq({name, "_timeout"}, longint'(done), 1);
    chk_eq({name, "_busy_rise"}, rise_cyc - run_cyc, 1);
    chk_eq({name, "_len_err_cnt"}, errs, exp_err ? 1 : 0);
    if (exp_err) chk_eq({name, "_len_err_cyc"}, err_cyc - run_cyc, 1);
    chk_eq({name, "_words"}, words, n);
    chk_eq({name, "_reads"}, rds, n);
    chk_eq({name, "_sb_empty"}, sb.size(), 0);
    if (n == 0) begin
      chk_eq({name, "_busy_cycles"}, busy_cycles, 1);
      chk_eq({name, "_no_valid"}, fv_cyc, -1);
    end else begin
      chk_eq({name, "_first_valid"}, fv_cyc - run_cyc, LAT + 2);
      chk_eq({name, "_busy_fall"}, fall_cyc - lhs_cyc, 2);
      chk_eq({name, "_first_rd"}, first_rd - run_cyc, 1);
      if (rmode == 0) begin
        chk_eq({name, "_rd_span"}, last_rd - first_rd, n - 1);
        chk_eq({name, "_out_span"}, lhs_cyc - fv_cyc, n - 1);
      end else begin
        chk_ok({name, "_rd_stalled"}, (last_rd - first_rd) > int'(n - 1), last_rd - first_rd);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    dpram_run = 1'b0;
    dpram_len = 16'd0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_xfer("l8",       8,      16'h1111, 0, -1, -1);
    do_xfer("l16_slow", 16,     16'h2222, 1, -1, -1);
    do_xfer("l0",       0,      16'h3333, 0, -1, -1);
    do_xfer("lbig",     D + 5,  16'h4444, 0, -1, -1);
    do_xfer("repulse",  10,     16'h5555, 0, 3, -1);
    do_xfer("rst20",    20,     16'h6666, 0, -1, 4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_xfer("after_rst", 2,     16'h7777, 0, -1, -1);

    chk_eq("fifo_overflow", ovf, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
